// File: rtl/issue_scheduler_if.sv
// Issue scheduler bus interface.
// Carries three groups of signals between an instruction source/datapath
// and the scheduler:
//   - instruction input: instv, opcode, imm, src1, src2, dst, in_ready
//   - issue handshake:   iss_valid, iss_ready, iss_opcode, iss_imm,
//                        iss_src1, iss_src2, iss_dst
//   - writeback/status:  wb_valid, wb_dst, busy, overflow
// The master modport is the environment side (instruction source plus
// datapath). The slave modport is the scheduler side.
interface issue_scheduler_if #(
  parameter int OPC_W  = 4,
  parameter int DATA_W = 8,
  parameter int REG_W  = 2
);
  logic              instv;
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] imm;
  logic [REG_W-1:0]  src1;
  logic [REG_W-1:0]  src2;
  logic [REG_W-1:0]  dst;
  logic              in_ready;

  logic              iss_valid;
  logic              iss_ready;
  logic [OPC_W-1:0]  iss_opcode;
  logic [DATA_W-1:0] iss_imm;
  logic [REG_W-1:0]  iss_src1;
  logic [REG_W-1:0]  iss_src2;
  logic [REG_W-1:0]  iss_dst;

  logic              wb_valid;
  logic [REG_W-1:0]  wb_dst;
  logic              busy;
  logic              overflow;

  modport master (
    output instv, opcode, imm, src1, src2, dst, iss_ready, wb_valid, wb_dst,
    input  in_ready, iss_valid, iss_opcode, iss_imm, iss_src1, iss_src2,
           iss_dst, busy, overflow
  );

  modport slave (
    input  instv, opcode, imm, src1, src2, dst, iss_ready, wb_valid, wb_dst,
    output in_ready, iss_valid, iss_opcode, iss_imm, iss_src1, iss_src2,
           iss_dst, busy, overflow
  );
endinterface

// File: rtl/issue_scheduler.sv
// In-order issue scheduler.
// Instructions are buffered in a FIFO of DEPTH entries. A scoreboard
// holds one pending bit per architectural register. The FIFO head is
// offered to the datapath only when none of its src1, src2 or dst
// registers is pending. This blocks both RAW and WAW hazards.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - issue_scheduler_if.slave (instruction in, issue, writeback,
//            status)
module issue_scheduler #(
  parameter int DEPTH  = 4,
  parameter int OPC_W  = 4,
  parameter int DATA_W = 8,
  parameter int REG_W  = 2
) (
  input  logic clock,
  input  logic reset,
  issue_scheduler_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 1 << REG_W;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  src1;
    logic [REG_W-1:0]  src2;
    logic [REG_W-1:0]  dst;
  } entry_t;

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [NREG-1:0]  pending_r;
  logic             overflow_r;

  entry_t           entry_in_s;
  entry_t           head_s;
  logic             full_s;
  logic             empty_s;
  logic             hazard_s;
  logic             iss_valid_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [NREG-1:0]  pending_nxt_s;

  assign entry_in_s = '{opcode: bus.opcode, imm: bus.imm, src1: bus.src1,
                        src2: bus.src2, dst: bus.dst};
  assign head_s     = mem_r[rd_ptr_r];
  assign full_s     = (count_r == CNT_W'(DEPTH));
  assign empty_s    = (count_r == CNT_W'(0));

  // Head is blocked while any register it reads or writes is still in flight.
  assign hazard_s    = pending_r[head_s.src1] | pending_r[head_s.src2] |
                       pending_r[head_s.dst];
  // Built only from registered state, so no input reaches iss_valid
  // combinationally.
  assign iss_valid_s = !empty_s && !hazard_s;

  // in_ready comes from the registered count. A push while full is
  // dropped even when the same cycle pops.
  assign push_s = bus.instv && !full_s;
  assign pop_s  = iss_valid_s && bus.iss_ready;

  // Next FIFO occupancy.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Next scoreboard. The writeback clear is applied first so that the
  // issue set wins when both target the same register.
  always_comb begin
    pending_nxt_s = pending_r;
    if (bus.wb_valid) begin
      pending_nxt_s[bus.wb_dst] = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (pop_s) begin
      pending_nxt_s[head_s.dst] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // FIFO storage, pointers, count, scoreboard and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      pending_r  <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= entry_in_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (bus.instv && full_s) begin
        overflow_r <= 1'b1;
      end
      count_r   <= count_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  assign bus.in_ready   = !full_s;
  assign bus.iss_valid  = iss_valid_s;
  assign bus.iss_opcode = head_s.opcode;
  assign bus.iss_imm    = head_s.imm;
  assign bus.iss_src1   = head_s.src1;
  assign bus.iss_src2   = head_s.src2;
  assign bus.iss_dst    = head_s.dst;
  assign bus.busy       = !empty_s || (pending_r != '0);
  assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] imm;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] d;
  } ent_t;

  typedef struct {
    logic       v;
    ent_t       e;
    logic       rdy;
    logic       wbv;
    logic [1:0] wbd;
    logic       x_valid;
    logic       x_in_ready;
    logic       x_busy;
  } vec_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  // reference model state
  ent_t       q[$];
  logic [3:0] pend;
  logic       ovf;

  issue_scheduler_if #(.OPC_W(4), .DATA_W(8), .REG_W(2)) bus ();

  issue_scheduler #(.DEPTH(DEPTH), .OPC_W(4), .DATA_W(8), .REG_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hazard(input ent_t e);
    return pend[e.s1] | pend[e.s2] | pend[e.d];
  endfunction

  task automatic model_reset();
    q.delete();
    pend = 4'b0000;
    ovf  = 1'b0;
  endtask

  task automatic drive(input logic v, input ent_t e, input logic rdy,
                       input logic wbv, input logic [1:0] wbd);
    bus.instv     = v;
    bus.opcode    = e.op;
    bus.imm       = e.imm;
    bus.src1      = e.s1;
    bus.src2      = e.s2;
    bus.dst       = e.d;
    bus.iss_ready = rdy;
    bus.wb_valid  = wbv;
    bus.wb_dst    = wbd;
  endtask

  // Compare the DUT against the model, advance the model and cross one edge.
  task automatic model_step();
    logic exp_rdy;
    logic exp_valid;
    logic exp_busy;
    ent_t head;
    exp_rdy   = (q.size() < DEPTH);
    exp_valid = 1'b0;
    head      = '0;
    if (q.size() != 0) begin
      head      = q[0];
      exp_valid = !hazard(head);
    end
    exp_busy = (q.size() != 0) || (pend != 4'b0000);
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("iss_valid", 32'(bus.iss_valid), 32'(exp_valid));
    check("busy", 32'(bus.busy), 32'(exp_busy));
    check("overflow", 32'(bus.overflow), 32'(ovf));
    if (exp_valid && bus.iss_valid) begin
      check("iss_fields",
            32'({bus.iss_opcode, bus.iss_imm, bus.iss_src1, bus.iss_src2, bus.iss_dst}),
            32'(head));
    end
    if (bus.wb_valid) pend[bus.wb_dst] = 1'b0;
    if (exp_valid && bus.iss_ready) begin
      pend[head.d] = 1'b1;
      void'(q.pop_front());
    end
    if (bus.instv) begin
      if (exp_rdy) q.push_back(ent_t'({bus.opcode, bus.imm, bus.src1, bus.src2, bus.dst}));
      else ovf = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic cycle(input logic v, input ent_t e, input logic rdy,
                       input logic wbv, input logic [1:0] wbd);
    drive(v, e, rdy, wbv, wbd);
    #1;
    model_step();
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, rdy, 1'b0, 2'd0);
  endtask

  task automatic wb(input logic [1:0] r);
    cycle(1'b0, '0, 1'b1, 1'b1, r);
  endtask

  task automatic clear_all();
    for (int r = 0; r < 4; r++) wb(2'(r));
    idle(1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_iss_valid"}, 32'(bus.iss_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0);

    // Independent stream: I0 issues at once, I1..I3 wait on r0.
    tbl[0]  = '{1'b1, ent_t'{4'd1, 8'h10, 2'd0, 2'd0, 2'd0}, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, ent_t'{4'd2, 8'h11, 2'd0, 2'd0, 2'd1}, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, ent_t'{4'd3, 8'h12, 2'd0, 2'd0, 2'd2}, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, ent_t'{4'd4, 8'h13, 2'd0, 2'd0, 2'd3}, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, ent_t'('0), 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, ent_t'('0), 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, ent_t'('0), 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, ent_t'('0), 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, ent_t'('0), 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, ent_t'('0), 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, ent_t'('0), 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, ent_t'('0), 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};

    // Reset held across edges, then released away from the edge.
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_idle_outputs("rst_hold");
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_idle_outputs("rst_release");

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].e, tbl[i].rdy, tbl[i].wbv, tbl[i].wbd);
      #1;
      check($sformatf("tbl%0d_valid", i), 32'(bus.iss_valid), 32'(tbl[i].x_valid));
      check($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].x_in_ready));
      check($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].x_busy));
      model_step();
    end

    // RAW: second instruction reads r2 written by the first.
    cycle(1'b1, ent_t'{4'd1, 8'h21, 2'd0, 2'd0, 2'd2}, 1'b1, 1'b0, 2'd0);
    cycle(1'b1, ent_t'{4'd5, 8'h22, 2'd2, 2'd0, 2'd1}, 1'b1, 1'b0, 2'd0);
    repeat (3) idle(1'b1);
    check("raw_stalled", 32'(bus.iss_valid), 32'd0);
    wb(2'd2);
    check("raw_released", 32'(bus.iss_valid), 32'd1);
    check("raw_src1", 32'(bus.iss_src1), 32'd2);
    idle(1'b1);
    clear_all();

    // Backpressure: head held for 5 cycles with iss_ready low.
    cycle(1'b1, ent_t'{4'd7, 8'hA5, 2'd1, 2'd2, 2'd3}, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      check("bp_imm", 32'(bus.iss_imm), 32'hA5);
      idle(1'b0);
    end
    idle(1'b1);
    check("bp_accepted", 32'(bus.busy), 32'd1);
    clear_all();

    // Full/overflow: five pushes with iss_ready low, then drain.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, ent_t'{4'(k), 8'(8'h30 + k), 2'(k), 2'(k), 2'(k)}, 1'b0, 1'b0, 2'd0);
    end
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_overflow", 32'(bus.overflow), 32'd1);
    // Push while full with a pop in the same cycle is still a drop.
    cycle(1'b1, ent_t'{4'hF, 8'hEE, 2'd0, 2'd0, 2'd0}, 1'b1, 1'b0, 2'd0);
    repeat (4) idle(1'b1);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    clear_all();

    // Mid-stream reset with three entries queued.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, ent_t'{4'd9, 8'(8'h40 + k), 2'd0, 2'd0, 2'(k)}, 1'b0, 1'b0, 2'd0);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle(1'b1);

    // WAW: both instructions write r3.
    cycle(1'b1, ent_t'{4'd2, 8'h51, 2'd0, 2'd0, 2'd3}, 1'b1, 1'b0, 2'd0);
    cycle(1'b1, ent_t'{4'd3, 8'h52, 2'd1, 2'd1, 2'd3}, 1'b1, 1'b0, 2'd0);
    repeat (3) idle(1'b1);
    check("waw_stalled", 32'(bus.iss_valid), 32'd0);
    wb(2'd3);
    check("waw_released", 32'(bus.iss_valid), 32'd1);
    idle(1'b1);
    check("waw_busy_before_wb", 32'(bus.busy), 32'd1);
    wb(2'd3);
    check("waw_busy_after_wb", 32'(bus.busy), 32'd0);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
